// File: rtl/sram_like_mem_arbiter.sv
// -----------------------------------------------------------------------------
// sram_like_mem_arbiter
//
// Purpose:
//   Shares one downstream SRAM-like memory port between the instruction-fetch
//   port (read-only) and the exe/mem data port. Data has fixed priority; a
//   starvation guard forces a waiting fetch ahead after FAIR_LIMIT consecutive
//   data grants. Accepted requests are remembered in an owner FIFO so that the
//   in-order downstream responses can be routed back to the port that issued
//   them.
//
// Parameters:
//   OUTSTANDING  max accepted-but-unanswered requests (power of two, 2..8)
//   FAIR_LIMIT   data grants in a row while inst_req waits before inst wins (1..15)
//
// Ports:
//   clk, reset                       clock; synchronous active-high reset
//   inst_req/size/addr               fetch request in (held until inst_addr_ok)
//   inst_addr_ok/data_ok/rdata       fetch handshake and response out
//   data_req/wr/size/addr/wstrb/wdata data request in (held until data_addr_ok)
//   data_addr_ok/data_ok/rdata       data handshake and response out
//   mem_req/wr/size/addr/wstrb/wdata downstream request out (combinational)
//   mem_addr_ok/data_ok/rdata        downstream handshake and response in
// -----------------------------------------------------------------------------
module sram_like_mem_arbiter #(
    parameter int OUTSTANDING = 2,
    parameter int FAIR_LIMIT  = 4
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        inst_req,
    input  logic [1:0]  inst_size,
    input  logic [31:0] inst_addr,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,

    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,

    output logic        mem_req,
    output logic        mem_wr,
    output logic [1:0]  mem_size,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata
);

    localparam int PTR_W = $clog2(OUTSTANDING);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOCK_I = 2'd1,
        LOCK_D = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;

    logic             sel_inst;   // 1 = fetch port owns the grant this cycle
    logic             sel_req;    // the selected port is requesting
    logic             accept;
    logic             pop;
    logic             head_inst;
    logic             fifo_full;
    logic             fifo_empty;

    logic             owner_q [OUTSTANDING];  // 1 = entry belongs to fetch
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [3:0]       starve_cnt;

    assign fifo_full  = (count == CNT_W'(OUTSTANDING));
    assign fifo_empty = (count == '0);

    // Grant selection. Once a request has been presented downstream the
    // grant is locked to it until accepted, so the downstream port never
    // sees a request withdrawn or swapped.
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        sel_inst = 1'b0;
        sel_req  = 1'b0;
        case (state)
            LOCK_I: begin
                sel_inst = 1'b1;
                sel_req  = inst_req;
            end
            LOCK_D: begin
                sel_inst = 1'b0;
                sel_req  = data_req;
            end
            default: begin
                if (inst_req && (!data_req || starve_cnt == 4'(FAIR_LIMIT))) begin
                    sel_inst = 1'b1;
                    sel_req  = 1'b1;
                end else begin
                    sel_inst = 1'b0;
                    sel_req  = data_req;
                end
            end
        endcase
    end

    // A full FIFO blocks new requests even if a response pops this cycle;
    // this keeps mem_req independent of mem_data_ok.
    assign mem_req   = sel_req && !fifo_full && !reset;
    assign mem_wr    = sel_inst ? 1'b0  : data_wr;
    assign mem_size  = sel_inst ? inst_size : data_size;
    assign mem_addr  = sel_inst ? inst_addr : data_addr;
    assign mem_wstrb = sel_inst ? 4'b0  : data_wstrb;
    assign mem_wdata = sel_inst ? 32'b0 : data_wdata;

    assign accept       = mem_req && mem_addr_ok;
    assign inst_addr_ok = accept && sel_inst;
    assign data_addr_ok = accept && !sel_inst;

    // Responses with nothing outstanding are a downstream protocol error and
    // are dropped rather than corrupting the pointers.
    assign pop          = mem_data_ok && !fifo_empty && !reset;
    assign head_inst    = owner_q[rd_ptr];
    assign inst_data_ok = pop && head_inst;
    assign data_data_ok = pop && !head_inst;
    assign inst_rdata   = mem_rdata;
    assign data_rdata   = mem_rdata;

    always_comb begin
        state_next = state;
        if (accept) begin
            state_next = IDLE;
        end else if (mem_req) begin
            state_next = sel_inst ? LOCK_I : LOCK_D;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            starve_cnt <= '0;
        end else begin
            state <= state_next;

            if (accept) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)    rd_ptr <= rd_ptr + PTR_W'(1);

            case ({accept, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase

            if (!inst_req) begin
                starve_cnt <= '0;
            end else if (accept && sel_inst) begin
                starve_cnt <= '0;
            end else if (accept && starve_cnt != 4'(FAIR_LIMIT)) begin
                starve_cnt <= starve_cnt + 4'd1;
            end
        end
    end

    // NOTE: the owner storage has no reset; entries are only read between a
    // push and its pop, and the pointers/count are what reset clears.
    always_ff @(posedge clk) begin
        if (accept) begin
            owner_q[wr_ptr] <= sel_inst;
        end
    end

endmodule

// File: tb/tb_sram_like_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sram_like_mem_arbiter
//
// Purpose:
//   Self-checking bench for sram_like_mem_arbiter. Directed scenarios (single
//   fetch, simultaneous requests, grant lock, full FIFO, fairness, reset with
//   requests outstanding) followed by a randomized phase. A reference model
//   built from an ordered queue of expected response owners and an integer
//   starvation count predicts every handshake each cycle.
// -----------------------------------------------------------------------------
module tb_sram_like_mem_arbiter;

    localparam int OUTSTANDING = 2;
    localparam int FAIR_LIMIT  = 4;
    localparam int NONE = 0, INST = 1, DATA = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        inst_req;
    logic [1:0]  inst_size;
    logic [31:0] inst_addr;
    logic        inst_addr_ok, inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req, data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [3:0]  data_wstrb;
    logic [31:0] data_wdata;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;
    logic        mem_req, mem_wr;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic        mem_addr_ok, mem_data_ok;
    logic [31:0] mem_rdata;

    sram_like_mem_arbiter #(
        .OUTSTANDING(OUTSTANDING),
        .FAIR_LIMIT (FAIR_LIMIT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .inst_req    (inst_req),
        .inst_size   (inst_size),
        .inst_addr   (inst_addr),
        .inst_addr_ok(inst_addr_ok),
        .inst_data_ok(inst_data_ok),
        .inst_rdata  (inst_rdata),
        .data_req    (data_req),
        .data_wr     (data_wr),
        .data_size   (data_size),
        .data_addr   (data_addr),
        .data_wstrb  (data_wstrb),
        .data_wdata  (data_wdata),
        .data_addr_ok(data_addr_ok),
        .data_data_ok(data_data_ok),
        .data_rdata  (data_rdata),
        .mem_req     (mem_req),
        .mem_wr      (mem_wr),
        .mem_size    (mem_size),
        .mem_addr    (mem_addr),
        .mem_wstrb   (mem_wstrb),
        .mem_wdata   (mem_wdata),
        .mem_addr_ok (mem_addr_ok),
        .mem_data_ok (mem_data_ok),
        .mem_rdata   (mem_rdata)
    );

    always #5 clk = ~clk;

    int unsigned compared   = 0;
    int unsigned mismatched = 0;

    // Reference model state
    int exp_owner[$];     // owners of accepted, unanswered requests, oldest first
    int pending_port = NONE;  // port offered downstream but not yet accepted
    int starve       = 0;
    bit last_inst_acc = 1'b0;
    bit last_data_acc = 1'b0;

    // Snapshot of DUT outputs at the most recent comparison point
    logic        s_mem_req, s_iaok, s_daok, s_idok, s_ddok, s_mem_wr;
    logic [31:0] s_mem_addr, s_irdata, s_drdata;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One clock cycle: inputs are already driven (after the falling edge);
    // compare outputs, then advance the model across the rising edge.
    task automatic step();
        int winner;
        bit full, e_req, e_acc, e_pop;
        int head;
        #2;
        s_mem_req  = mem_req;   s_iaok     = inst_addr_ok; s_daok   = data_addr_ok;
        s_idok     = inst_data_ok; s_ddok  = data_data_ok; s_mem_wr = mem_wr;
        s_mem_addr = mem_addr;  s_irdata   = inst_rdata;   s_drdata = data_rdata;
        if (reset) begin
            check("rst_mem_req",  mem_req,      1'b0);
            check("rst_inst_aok", inst_addr_ok, 1'b0);
            check("rst_data_aok", data_addr_ok, 1'b0);
            check("rst_inst_dok", inst_data_ok, 1'b0);
            check("rst_data_dok", data_data_ok, 1'b0);
            @(posedge clk);
            exp_owner.delete();
            pending_port  = NONE;
            starve        = 0;
            last_inst_acc = 1'b0;
            last_data_acc = 1'b0;
            @(negedge clk);
            return;
        end

        full = (exp_owner.size() >= OUTSTANDING);
        if (pending_port != NONE)                                  winner = pending_port;
        else if (inst_req && (!data_req || starve == FAIR_LIMIT)) winner = INST;
        else if (data_req)                                         winner = DATA;
        else                                                       winner = NONE;
        e_req = (winner != NONE) && !full;
        e_acc = e_req && mem_addr_ok;
        e_pop = mem_data_ok && (exp_owner.size() > 0);
        head  = e_pop ? exp_owner[0] : NONE;
        if (mem_data_ok && exp_owner.size() == 0)
            $display("note: mem_data_ok with nothing outstanding at %0t (protocol error, expect no upstream response)", $time);

        check("mem_req",  mem_req,      e_req);
        check("inst_aok", inst_addr_ok, e_acc && winner == INST);
        check("data_aok", data_addr_ok, e_acc && winner == DATA);
        check("inst_dok", inst_data_ok, head == INST);
        check("data_dok", data_data_ok, head == DATA);
        if (e_req && winner == INST) begin
            check("mem_addr_i",  mem_addr,  inst_addr);
            check("mem_size_i",  mem_size,  inst_size);
            check("mem_wr_i",    mem_wr,    1'b0);
            check("mem_wstrb_i", mem_wstrb, 4'b0);
            check("mem_wdata_i", mem_wdata, 32'b0);
        end
        if (e_req && winner == DATA) begin
            check("mem_addr_d",  mem_addr,  data_addr);
            check("mem_size_d",  mem_size,  data_size);
            check("mem_wr_d",    mem_wr,    data_wr);
            check("mem_wstrb_d", mem_wstrb, data_wstrb);
            check("mem_wdata_d", mem_wdata, data_wdata);
        end
        if (head == INST) check("inst_rdata", inst_rdata, mem_rdata);
        if (head == DATA) check("data_rdata", data_rdata, mem_rdata);

        @(posedge clk);
        if (e_pop) void'(exp_owner.pop_front());
        if (e_acc) exp_owner.push_back(winner);
        if (!inst_req)                                     starve = 0;
        else if (e_acc && winner == INST)                  starve = 0;
        else if (e_acc && starve < FAIR_LIMIT)             starve = starve + 1;
        pending_port  = e_acc ? NONE : (e_req ? winner : pending_port);
        last_inst_acc = e_acc && winner == INST;
        last_data_acc = e_acc && winner == DATA;
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        inst_req = 1'b0; inst_size = 2'd2; inst_addr = 32'h0;
        data_req = 1'b0; data_wr = 1'b0; data_size = 2'd2; data_addr = 32'h0;
        data_wstrb = 4'h0; data_wdata = 32'h0;
        mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = 32'h0;
    endtask

    task automatic set_data(input bit wr, input logic [31:0] addr, input logic [31:0] wdata);
        data_req = 1'b1; data_wr = wr; data_size = 2'd2; data_addr = addr;
        data_wstrb = wr ? 4'hF : 4'h0; data_wdata = wdata;
    endtask

    // Return every outstanding response so the next scenario starts empty.
    task automatic drain();
        inst_req = 1'b0; data_req = 1'b0; mem_addr_ok = 1'b0;
        for (int k = 0; k < 2 * OUTSTANDING && exp_owner.size() > 0; k++) begin
            mem_data_ok = 1'b1;
            mem_rdata   = $urandom;
            step();
        end
        mem_data_ok = 1'b0;
        check("drained", 32'(exp_owner.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        idle_inputs();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        step();

        // Single fetch: accepted at cycle 0, answered at cycle 2
        inst_req = 1'b1; inst_addr = 32'h1C00_0000; mem_addr_ok = 1'b1;
        step();
        check("fetch_aok",   s_iaok,     1'b1);
        check("fetch_maddr", s_mem_addr, 32'h1C00_0000);
        inst_req = 1'b0; mem_addr_ok = 1'b0;
        step();
        mem_data_ok = 1'b1; mem_rdata = 32'h0280_0C0C;
        step();
        check("fetch_dok",   s_idok,   1'b1);
        check("fetch_rdata", s_irdata, 32'h0280_0C0C);
        check("fetch_ddok",  s_ddok,   1'b0);
        mem_data_ok = 1'b0;

        // Simultaneous requests: data first, fetch next cycle
        inst_req = 1'b1; inst_addr = 32'h1C00_0004; mem_addr_ok = 1'b1;
        set_data(1'b0, 32'h0000_1000, 32'h0);
        step();
        check("simul_d_first", s_daok, 1'b1);
        check("simul_i_wait",  s_iaok, 1'b0);
        data_req = 1'b0;
        step();
        check("simul_i_second", s_iaok, 1'b1);
        inst_req = 1'b0; mem_addr_ok = 1'b0;
        step();
        mem_data_ok = 1'b1; mem_rdata = 32'hDA7A_0001;
        step();
        check("simul_ddok", s_ddok, 1'b1);
        mem_rdata = 32'h1A57_0002;
        step();
        check("simul_idok", s_idok, 1'b1);
        mem_data_ok = 1'b0;

        // Lock: fetch stalled 3 cycles, data arrives meanwhile but must wait
        inst_req = 1'b1; inst_addr = 32'h1C00_0010; mem_addr_ok = 1'b0;
        step();
        check("lock_c0_addr", s_mem_addr, 32'h1C00_0010);
        set_data(1'b1, 32'h0000_2000, 32'hCAFE_F00D);
        step();
        check("lock_c1_addr", s_mem_addr, 32'h1C00_0010);
        check("lock_c1_wr",   s_mem_wr,   1'b0);
        step();
        check("lock_c2_addr", s_mem_addr, 32'h1C00_0010);
        mem_addr_ok = 1'b1;
        step();
        check("lock_c3_iaok", s_iaok, 1'b1);
        check("lock_c3_daok", s_daok, 1'b0);
        inst_req = 1'b0;
        step();
        check("lock_c4_daok", s_daok,     1'b1);
        check("lock_c4_addr", s_mem_addr, 32'h0000_2000);
        drain();

        // Full owner FIFO blocks a third request, even on the popping cycle
        mem_addr_ok = 1'b1;
        set_data(1'b0, 32'h0000_3000, 32'h0);
        step();
        set_data(1'b0, 32'h0000_3004, 32'h0);
        step();
        set_data(1'b0, 32'h0000_3008, 32'h0);
        step();
        check("full_no_req", s_mem_req, 1'b0);
        check("full_no_aok", s_daok,    1'b0);
        mem_data_ok = 1'b1; mem_rdata = 32'h0000_0333;
        step();
        check("full_pop_no_req", s_mem_req, 1'b0);
        check("full_pop_dok",    s_ddok,    1'b1);
        mem_data_ok = 1'b0;
        step();
        check("full_then_aok", s_daok, 1'b1);
        drain();

        // Fairness: both held high, grants D,D,D,D,I repeating
        inst_req = 1'b1; inst_addr = 32'h1C00_0020; mem_addr_ok = 1'b1;
        set_data(1'b0, 32'h0000_4000, 32'h0);
        for (int i = 0; i < 10; i++) begin
            mem_data_ok = (exp_owner.size() > 0);
            mem_rdata   = $urandom;
            step();
            check($sformatf("fair_i_%0d", i), s_iaok, (i % 5) == 4);
            check($sformatf("fair_d_%0d", i), s_daok, (i % 5) != 4);
        end
        drain();

        // Reset with two outstanding: everything discarded
        mem_addr_ok = 1'b1;
        set_data(1'b0, 32'h0000_5000, 32'h0);
        step();
        set_data(1'b0, 32'h0000_5004, 32'h0);
        step();
        data_req = 1'b0; inst_req = 1'b1; inst_addr = 32'h1C00_0030;
        reset = 1'b1; mem_data_ok = 1'b1; mem_rdata = 32'h0BAD_0BAD;
        step();
        check("rst_snap_req", s_mem_req, 1'b0);
        check("rst_snap_dok", s_ddok,    1'b0);
        reset = 1'b0; inst_req = 1'b0; mem_data_ok = 1'b1;
        step();
        check("late_ddok", s_ddok, 1'b0);
        check("late_idok", s_idok, 1'b0);
        mem_data_ok = 1'b0; inst_req = 1'b1;
        step();
        check("post_rst_req", s_mem_req, 1'b1);
        check("post_rst_aok", s_iaok,    1'b1);
        drain();

        // Randomized traffic against the model
        for (int cyc = 0; cyc < 600; cyc++) begin
            if (last_inst_acc) inst_req = 1'b0;
            if (!inst_req && $urandom_range(0, 3) != 0) begin
                inst_req  = 1'b1;
                inst_addr = $urandom & 32'hFFFF_FFFC;
                inst_size = 2'd2;
            end
            if (last_data_acc) data_req = 1'b0;
            if (!data_req && $urandom_range(0, 2) != 0) begin
                data_req   = 1'b1;
                data_wr    = 1'($urandom_range(0, 1));
                data_size  = 2'($urandom_range(0, 2));
                data_addr  = $urandom;
                data_wstrb = 4'($urandom);
                data_wdata = $urandom;
            end
            mem_addr_ok = ($urandom_range(0, 3) != 0);
            mem_data_ok = (exp_owner.size() > 0) && ($urandom_range(0, 2) != 0);
            mem_rdata   = $urandom;
            step();
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
